axi4_sram_responder: RTL and testbench

- AXI4 slave (responder) backed by an internal word-addressed SRAM array.
- Sits opposite the AXI4 master BFM on the S_AXI_* bus. It accepts write and read bursts and returns B/R responses.
- Used as a golden, protocol-checking memory target for master-side RTL and BFM regression.
- Write and read channels run independently, with one outstanding transaction per direction.

---
 rtl/axi4_slv_pkg.sv | 30 +++
 rtl/axi4_burst_addr_gen.sv | 30 +++
 rtl/axi4_sram_responder.sv | 289 ++++++++++++++++++++++++++++
 tb/tb_axi4_sram_responder.sv | 475 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi4_slv_pkg.sv
// Shared types and constants for the AXI4 SRAM responder and its address generator.
// Optional error checking in the responder is enabled with AXI_SLV_ERR_CHECK_EN.
package axi4_slv_pkg;

  localparam int unsigned AXI_ID_W = 8;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
  typedef enum logic {R_IDLE, R_DATA} r_state_t;

  // id is sized for the widest supported ID; the responder uses the low C_ID_WIDTH bits
  typedef struct packed {
    logic [AXI_ID_W-1:0] id;
    logic [31:0]         addr;
    logic [7:0]          len;
    logic [2:0]          size;
    logic [1:0]          burst;
  } axi_cmd_t;

  function automatic logic wrap_bad(input axi_cmd_t cmd);
    return (cmd.burst == BURST_WRAP) && !(cmd.len inside {8'd1, 8'd3, 8'd7, 8'd15});
  endfunction

endpackage

// File: rtl/axi4_burst_addr_gen.sv
// Combinational next-beat address for FIXED, INCR and WRAP bursts.
// Reserved burst type behaves as INCR; transfer sizes above 4 bytes are clamped to 4.
module axi4_burst_addr_gen
  import axi4_slv_pkg::*;
(
  input  axi_cmd_t    cmd,
  input  logic [31:0] addr,
  output logic [31:0] next_addr
);

  logic [1:0]  size_eff;
  logic [31:0] step;
  logic [31:0] bound;

  always_comb begin
    size_eff  = (cmd.size > 3'd2) ? 2'd2 : cmd.size[1:0];
    step      = 32'd1 << size_eff;
    bound     = step * ({24'd0, cmd.len} + 32'd1);
    next_addr = addr + step;
    case (cmd.burst)
      BURST_FIXED: next_addr = addr;
      BURST_WRAP:  next_addr = (addr & ~(bound - 32'd1)) | ((addr + step) & (bound - 32'd1));
      default:     next_addr = addr + step;
    endcase
  end

  logic unused_cmd;
  assign unused_cmd = ^{cmd.id, cmd.addr};

endmodule

// File: rtl/axi4_sram_responder.sv
// AXI4 slave backed by a word-addressed SRAM; independent write and read FSMs, one
// outstanding burst each. Define AXI_SLV_ERR_CHECK_EN for range/WLAST/WRAP-length checks.
module axi4_sram_responder
  import axi4_slv_pkg::*;
#(
  parameter int unsigned C_ID_WIDTH   = 1,
  parameter int unsigned C_ADDR_WIDTH = 32,
  parameter int unsigned C_DATA_WIDTH = 32,
  parameter int unsigned C_MEM_WORDS  = 1024,
  parameter logic [31:0] C_BASE_ADDR  = 32'h0000_0000
) (
  input  logic                    ACLK,
  input  logic                    ARESETN,
  input  logic [C_ID_WIDTH-1:0]   S_AXI_AWID,
  input  logic [C_ADDR_WIDTH-1:0] S_AXI_AWADDR,
  input  logic [7:0]              S_AXI_AWLEN,
  input  logic [2:0]              S_AXI_AWSIZE,
  input  logic [1:0]              S_AXI_AWBURST,
  input  logic [1:0]              S_AXI_AWLOCK,
  input  logic [3:0]              S_AXI_AWCACHE,
  input  logic [2:0]              S_AXI_AWPROT,
  input  logic [3:0]              S_AXI_AWREGION,
  input  logic [3:0]              S_AXI_AWQOS,
  input  logic                    S_AXI_AWUSER,
  input  logic                    S_AXI_AWVALID,
  output logic                    S_AXI_AWREADY,
  input  logic [C_ID_WIDTH-1:0]   S_AXI_WID,
  input  logic [C_DATA_WIDTH-1:0] S_AXI_WDATA,
  input  logic [3:0]              S_AXI_WSTRB,
  input  logic                    S_AXI_WLAST,
  input  logic                    S_AXI_WUSER,
  input  logic                    S_AXI_WVALID,
  output logic                    S_AXI_WREADY,
  output logic [C_ID_WIDTH-1:0]   S_AXI_BID,
  output logic [1:0]              S_AXI_BRESP,
  output logic                    S_AXI_BUSER,
  output logic                    S_AXI_BVALID,
  input  logic                    S_AXI_BREADY,
  input  logic [C_ID_WIDTH-1:0]   S_AXI_ARID,
  input  logic [C_ADDR_WIDTH-1:0] S_AXI_ARADDR,
  input  logic [7:0]              S_AXI_ARLEN,
  input  logic [2:0]              S_AXI_ARSIZE,
  input  logic [1:0]              S_AXI_ARBURST,
  input  logic [1:0]              S_AXI_ARLOCK,
  input  logic [3:0]              S_AXI_ARCACHE,
  input  logic [2:0]              S_AXI_ARPROT,
  input  logic [3:0]              S_AXI_ARREGION,
  input  logic [3:0]              S_AXI_ARQOS,
  input  logic                    S_AXI_ARUSER,
  input  logic                    S_AXI_ARVALID,
  output logic                    S_AXI_ARREADY,
  output logic [C_ID_WIDTH-1:0]   S_AXI_RID,
  output logic [C_DATA_WIDTH-1:0] S_AXI_RDATA,
  output logic [1:0]              S_AXI_RRESP,
  output logic                    S_AXI_RLAST,
  output logic                    S_AXI_RUSER,
  output logic                    S_AXI_RVALID,
  input  logic                    S_AXI_RREADY
);

  localparam int unsigned IDX_W = $clog2(C_MEM_WORDS);

  logic [31:0] mem [C_MEM_WORDS];

  function automatic logic [IDX_W-1:0] word_idx(input logic [31:0] a);
    return IDX_W'((a - C_BASE_ADDR) >> 2);
  endfunction

`ifdef AXI_SLV_ERR_CHECK_EN
  function automatic logic in_range(input logic [31:0] a);
    logic [32:0] off;
    off = {1'b0, a} - {1'b0, C_BASE_ADDR};
    return !off[32] && (off[31:0] < 32'(4 * C_MEM_WORDS));
  endfunction
`endif

  w_state_t    w_state;
  axi_cmd_t    w_cmd, aw_cmd;
  logic [31:0] w_addr, w_addr_nxt;
  logic [7:0]  w_beat;
  logic        w_err, beat_err, beat_ok, aw_wrap_bad;
  logic        awready_q, wready_q, bvalid_q;
  logic [C_ID_WIDTH-1:0] bid_q;
  logic [1:0]  bresp_q;

  r_state_t    r_state;
  axi_cmd_t    r_cmd, ar_cmd;
  logic [31:0] r_addr, r_addr_nxt, r_fetch_addr, rdata_nxt;
  logic [7:0]  r_beat;
  logic [1:0]  rresp_nxt;
  logic        arready_q, rvalid_q, rlast_q;
  logic [C_ID_WIDTH-1:0] rid_q;
  logic [31:0] rdata_q;
  logic [1:0]  rresp_q;

  logic aw_hs, w_hs, ar_hs, r_hs;

  assign aw_hs = S_AXI_AWVALID & awready_q;
  assign w_hs  = S_AXI_WVALID & wready_q;
  assign ar_hs = S_AXI_ARVALID & arready_q;
  assign r_hs  = rvalid_q & S_AXI_RREADY;

  assign aw_cmd = '{id: AXI_ID_W'(S_AXI_AWID), addr: 32'(S_AXI_AWADDR), len: S_AXI_AWLEN,
                    size: S_AXI_AWSIZE, burst: S_AXI_AWBURST};
  assign ar_cmd = '{id: AXI_ID_W'(S_AXI_ARID), addr: 32'(S_AXI_ARADDR), len: S_AXI_ARLEN,
                    size: S_AXI_ARSIZE, burst: S_AXI_ARBURST};

  axi4_burst_addr_gen u_w_addr_gen (
    .cmd       (w_cmd),
    .addr      (w_addr),
    .next_addr (w_addr_nxt)
  );

  axi4_burst_addr_gen u_r_addr_gen (
    .cmd       (r_cmd),
    .addr      (r_addr),
    .next_addr (r_addr_nxt)
  );

  always_comb begin
    beat_ok     = 1'b1;
    beat_err    = 1'b0;
    aw_wrap_bad = 1'b0;
`ifdef AXI_SLV_ERR_CHECK_EN
    beat_ok     = in_range(w_addr);
    beat_err    = !beat_ok || (S_AXI_WLAST != (w_beat == w_cmd.len));
    aw_wrap_bad = wrap_bad(aw_cmd);
`endif
  end

  // SRAM is deliberately left out of reset
  always_ff @(posedge ACLK) begin
    if (w_hs && beat_ok) begin
      for (int b = 0; b < 4; b++) begin
        if (S_AXI_WSTRB[b]) mem[word_idx(w_addr)][8*b +: 8] <= S_AXI_WDATA[8*b +: 8];
      end
    end
  end

  // Next R beat is fetched with the handshake that exposes it, so RDATA sees pre-write contents
  always_comb begin
    r_fetch_addr = ar_hs ? ar_cmd.addr : r_addr_nxt;
    rdata_nxt    = mem[word_idx(r_fetch_addr)];
    rresp_nxt    = RESP_OKAY;
`ifdef AXI_SLV_ERR_CHECK_EN
    if (!in_range(r_fetch_addr)) begin
      rdata_nxt = 32'hDEAD_BEEF;
      rresp_nxt = RESP_SLVERR;
    end
    if (wrap_bad(ar_hs ? ar_cmd : r_cmd)) rresp_nxt = RESP_SLVERR;
`endif
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      w_state   <= W_IDLE;
      w_cmd     <= '0;
      w_addr    <= '0;
      w_beat    <= '0;
      w_err     <= 1'b0;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      bid_q     <= '0;
      bresp_q   <= RESP_OKAY;
    end else begin
      unique case (w_state)
        W_IDLE: begin
          awready_q <= 1'b1;
          if (aw_hs) begin
            w_cmd     <= aw_cmd;
            w_addr    <= aw_cmd.addr;
            w_beat    <= '0;
            w_err     <= aw_wrap_bad;
            awready_q <= 1'b0;
            wready_q  <= 1'b1;
            w_state   <= W_DATA;
          end
        end
        W_DATA: begin
          if (w_hs) begin
            w_addr <= w_addr_nxt;
            w_beat <= w_beat + 8'd1;
            w_err  <= w_err | beat_err;
            if (w_beat == w_cmd.len) begin
              wready_q <= 1'b0;
              bvalid_q <= 1'b1;
              bid_q    <= w_cmd.id[C_ID_WIDTH-1:0];
              bresp_q  <= (w_err | beat_err) ? RESP_SLVERR : RESP_OKAY;
              w_state  <= W_RESP;
            end
          end
        end
        W_RESP: begin
          if (S_AXI_BREADY) begin
            bvalid_q  <= 1'b0;
            awready_q <= 1'b1;
            w_state   <= W_IDLE;
          end
        end
        default: w_state <= W_IDLE;
      endcase
    end
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      r_state   <= R_IDLE;
      r_cmd     <= '0;
      r_addr    <= '0;
      r_beat    <= '0;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rlast_q   <= 1'b0;
      rid_q     <= '0;
      rdata_q   <= '0;
      rresp_q   <= RESP_OKAY;
    end else begin
      unique case (r_state)
        R_IDLE: begin
          arready_q <= 1'b1;
          if (ar_hs) begin
            r_cmd     <= ar_cmd;
            r_addr    <= ar_cmd.addr;
            r_beat    <= '0;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b1;
            rdata_q   <= rdata_nxt;
            rresp_q   <= rresp_nxt;
            rlast_q   <= (ar_cmd.len == 8'd0);
            rid_q     <= S_AXI_ARID;
            r_state   <= R_DATA;
          end
        end
        R_DATA: begin
          if (r_hs) begin
            if (rlast_q) begin
              rvalid_q  <= 1'b0;
              rlast_q   <= 1'b0;
              arready_q <= 1'b1;
              r_state   <= R_IDLE;
            end else begin
              r_addr  <= r_addr_nxt;
              r_beat  <= r_beat + 8'd1;
              rdata_q <= rdata_nxt;
              rresp_q <= rresp_nxt;
              rlast_q <= ((r_beat + 8'd1) == r_cmd.len);
            end
          end
        end
        default: r_state <= R_IDLE;
      endcase
    end
  end

`ifdef AXI_SLV_ERR_CHECK_EN
  always @(posedge ACLK) begin
    if (ARESETN) begin
      if (aw_hs && aw_wrap_bad)
        $error("AXI slave: bad WRAP length on write id %0h addr %08h", S_AXI_AWID, aw_cmd.addr);
      if (w_hs && beat_err)
        $error("AXI slave: write beat error id %0h addr %08h", w_cmd.id, w_addr);
      if (r_hs && (rresp_q == RESP_SLVERR))
        $error("AXI slave: read beat error id %0h addr %08h", rid_q, r_addr);
    end
  end
`endif

  assign S_AXI_AWREADY = awready_q;
  assign S_AXI_WREADY  = wready_q;
  assign S_AXI_BID     = bid_q;
  assign S_AXI_BRESP   = bresp_q;
  assign S_AXI_BUSER   = 1'b0;
  assign S_AXI_BVALID  = bvalid_q;
  assign S_AXI_ARREADY = arready_q;
  assign S_AXI_RID     = rid_q;
  assign S_AXI_RDATA   = rdata_q;
  assign S_AXI_RRESP   = rresp_q;
  assign S_AXI_RLAST   = rlast_q;
  assign S_AXI_RUSER   = 1'b0;
  assign S_AXI_RVALID  = rvalid_q;

  logic unused_inputs;
  assign unused_inputs = ^{S_AXI_AWLOCK, S_AXI_AWCACHE, S_AXI_AWPROT, S_AXI_AWREGION,
                           S_AXI_AWQOS, S_AXI_AWUSER, S_AXI_WID, S_AXI_WUSER, S_AXI_WLAST,
                           S_AXI_ARLOCK, S_AXI_ARCACHE, S_AXI_ARPROT, S_AXI_ARREGION,
                           S_AXI_ARQOS, S_AXI_ARUSER, w_cmd, r_cmd};

endmodule

// File: tb/tb_axi4_sram_responder.sv
// Randomized self-checking bench for axi4_sram_responder against a word-array memory model.
// Error-response scenarios run only when AXI_SLV_ERR_CHECK_EN is defined.
module tb_axi4_sram_responder;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic        awid, awvalid, awready;
  logic [31:0] awaddr;
  logic [7:0]  awlen;
  logic [2:0]  awsize;
  logic [1:0]  awburst;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wlast, wvalid, wready;
  logic        bid, buser, bvalid, bready;
  logic [1:0]  bresp;
  logic        arid, arvalid, arready;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic        rid, rlast, ruser, rvalid, rready;
  logic [31:0] rdata;
  logic [1:0]  rresp;

  axi4_sram_responder dut (
    .ACLK           (clk),
    .ARESETN        (rst_n),
    .S_AXI_AWID     (awid),
    .S_AXI_AWADDR   (awaddr),
    .S_AXI_AWLEN    (awlen),
    .S_AXI_AWSIZE   (awsize),
    .S_AXI_AWBURST  (awburst),
    .S_AXI_AWLOCK   (2'b00),
    .S_AXI_AWCACHE  (4'h0),
    .S_AXI_AWPROT   (3'b000),
    .S_AXI_AWREGION (4'h0),
    .S_AXI_AWQOS    (4'h0),
    .S_AXI_AWUSER   (1'b0),
    .S_AXI_AWVALID  (awvalid),
    .S_AXI_AWREADY  (awready),
    .S_AXI_WID      (1'b0),
    .S_AXI_WDATA    (wdata),
    .S_AXI_WSTRB    (wstrb),
    .S_AXI_WLAST    (wlast),
    .S_AXI_WUSER    (1'b0),
    .S_AXI_WVALID   (wvalid),
    .S_AXI_WREADY   (wready),
    .S_AXI_BID      (bid),
    .S_AXI_BRESP    (bresp),
    .S_AXI_BUSER    (buser),
    .S_AXI_BVALID   (bvalid),
    .S_AXI_BREADY   (bready),
    .S_AXI_ARID     (arid),
    .S_AXI_ARADDR   (araddr),
    .S_AXI_ARLEN    (arlen),
    .S_AXI_ARSIZE   (arsize),
    .S_AXI_ARBURST  (arburst),
    .S_AXI_ARLOCK   (2'b00),
    .S_AXI_ARCACHE  (4'h0),
    .S_AXI_ARPROT   (3'b000),
    .S_AXI_ARREGION (4'h0),
    .S_AXI_ARQOS    (4'h0),
    .S_AXI_ARUSER   (1'b0),
    .S_AXI_ARVALID  (arvalid),
    .S_AXI_ARREADY  (arready),
    .S_AXI_RID      (rid),
    .S_AXI_RDATA    (rdata),
    .S_AXI_RRESP    (rresp),
    .S_AXI_RLAST    (rlast),
    .S_AXI_RUSER    (ruser),
    .S_AXI_RVALID   (rvalid),
    .S_AXI_RREADY   (rready)
  );

  int total  = 0;
  int passed = 0;
  bit gaps   = 1'b0;

  logic [31:0] model [1024];
  logic [31:0] wbuf [256];
  logic [3:0]  sbuf [256];
  logic [31:0] rbuf [256];
  logic        lbuf [256];
  logic [1:0]  pbuf [256];

  logic       lat_wready, b_stable, aw_back, b_id, r_id;
  logic [1:0] b_resp;
  int         b_lat, r_lat;

  // Beat address from the burst rules, for 4-byte beats
  function automatic logic [31:0] beat_addr(input logic [31:0] start, input int len,
                                            input logic [1:0] burst, input int i);
    int unsigned bound, lower;
    case (burst)
      2'b00: return start;
      2'b10: begin
        bound = 4 * (len + 1);
        lower = (start / bound) * bound;
        return lower + ((start - lower) + 4 * i) % bound;
      end
      default: return start + 32'(4 * i);
    endcase
  endfunction

  function automatic void model_write(input logic [31:0] a, input logic [31:0] d,
                                      input logic [3:0] s);
    for (int b = 0; b < 4; b++) if (s[b]) model[(a >> 2) & 32'h3FF][8*b +: 8] = d[8*b +: 8];
  endfunction

  task automatic wait_hi(input string what, ref logic sig);
    int t = 0;
    while (sig !== 1'b1 && t < 200) begin @(posedge clk); #1; t++; end
    if (t >= 200) begin
      total++;
      $display("FAIL %s_timeout got %b required 1", what, sig);
    end
  endtask

  task automatic axi_write(input logic id, input logic [31:0] addr, input int len,
                           input logic [1:0] burst, input int early_at, input int bwait);
    awid = id; awaddr = addr; awlen = 8'(len); awsize = 3'd2; awburst = burst; awvalid = 1'b1;
    wait_hi("awready", awready);
    @(posedge clk); #1;
    awvalid = 1'b0;
    lat_wready = wready;
    for (int i = 0; i <= len; i++) begin
      if (gaps) begin
        wvalid = 1'b0;
        repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      end
      wvalid = 1'b1; wdata = wbuf[i]; wstrb = sbuf[i];
      wlast = (early_at >= 0) ? (i == early_at) : (i == len);
      wait_hi("wready", wready);
      @(posedge clk); #1;
      model_write(beat_addr(addr, len, burst, i), wbuf[i], sbuf[i]);
    end
    wvalid = 1'b0; wlast = 1'b0;
    b_lat = 0;
    while (bvalid !== 1'b1 && b_lat < 200) begin @(posedge clk); #1; b_lat++; end
    b_id = bid; b_resp = bresp; b_stable = 1'b1;
    repeat (bwait) begin
      @(posedge clk); #1;
      if (bvalid !== 1'b1 || bid !== b_id || bresp !== b_resp) b_stable = 1'b0;
    end
    bready = 1'b1;
    @(posedge clk); #1;
    bready = 1'b0;
    aw_back = awready & ~bvalid;
  endtask

  task automatic axi_read(input logic id, input logic [31:0] addr, input int len,
                          input logic [1:0] burst);
    arid = id; araddr = addr; arlen = 8'(len); arsize = 3'd2; arburst = burst; arvalid = 1'b1;
    wait_hi("arready", arready);
    @(posedge clk); #1;
    arvalid = 1'b0;
    r_lat = 0;
    while (rvalid !== 1'b1 && r_lat < 200) begin @(posedge clk); #1; r_lat++; end
    r_id = rid;
    for (int i = 0; i <= len; i++) begin
      if (gaps) begin
        rready = 1'b0;
        repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      end
      rready = 1'b1;
      wait_hi("rvalid", rvalid);
      rbuf[i] = rdata; lbuf[i] = rlast; pbuf[i] = rresp;
      @(posedge clk); #1;
    end
    rready = 1'b0;
  endtask

  task automatic test_reset();
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if ({awready, wready, bvalid, arready, rvalid, rlast, bresp, rresp, rdata} !== '0)
      $display("FAIL reset_outputs got aw%b w%b b%b ar%b r%b l%b d%h required all 0",
               awready, wready, bvalid, arready, rvalid, rlast, rdata);
    else passed++;
    #2 rst_n = 1'b1;
    #1;
    total++;
    if ({awready, arready} !== 2'b00)
      $display("FAIL reset_release_before_edge got %b%b required 00", awready, arready);
    else passed++;
    @(posedge clk); #1;
    total++;
    if ({awready, arready} !== 2'b11)
      $display("FAIL reset_first_edge got %b%b required 11", awready, arready);
    else passed++;
  endtask

  task automatic test_single();
    wbuf[0] = 32'hA5A5_1234; sbuf[0] = 4'hF;
    axi_write(1'b1, 32'h10, 0, 2'b01, -1, 0);
    total++;
    if (lat_wready !== 1'b1) $display("FAIL single_wready_latency got %b required 1", lat_wready);
    else passed++;
    total++;
    if (b_lat !== 0) $display("FAIL single_b_latency got %0d required 0", b_lat);
    else passed++;
    total++;
    if ({b_id, b_resp} !== 3'b100) $display("FAIL single_bid_bresp got %b/%b required 1/00",
                                            b_id, b_resp);
    else passed++;
    total++;
    if (aw_back !== 1'b1) $display("FAIL single_awready_after_b got %b required 1", aw_back);
    else passed++;
    axi_read(1'b1, 32'h10, 0, 2'b01);
    total++;
    if (r_lat !== 0) $display("FAIL single_r_latency got %0d required 0", r_lat);
    else passed++;
    total++;
    if ({r_id, rbuf[0], lbuf[0], pbuf[0]} !== {1'b1, 32'hA5A5_1234, 1'b1, 2'b00})
      $display("FAIL single_read got id%b %h last%b resp%b required id1 a5a51234 last1 resp00",
               r_id, rbuf[0], lbuf[0], pbuf[0]);
    else passed++;
  endtask

  task automatic test_full_burst();
    for (int i = 0; i < 256; i++) begin wbuf[i] = $urandom; sbuf[i] = 4'hF; end
    axi_write(1'b0, 32'h0, 255, 2'b01, -1, 0);
    total++;
    if (b_lat !== 0 || b_resp !== 2'b00)
      $display("FAIL full_burst_b got lat%0d resp%b required lat0 resp00", b_lat, b_resp);
    else passed++;
    axi_read(1'b0, 32'h0, 255, 2'b01);
    for (int i = 0; i < 256; i++) begin
      total++;
      if (rbuf[i] !== wbuf[i] || lbuf[i] !== (i == 255))
        $display("FAIL full_burst_beat%0d got %h last%b required %h last%b",
                 i, rbuf[i], lbuf[i], wbuf[i], (i == 255));
      else passed++;
    end
  endtask

  task automatic test_incr();
    for (int i = 0; i < 4; i++) begin wbuf[i] = 32'(i + 1); sbuf[i] = 4'hF; end
    axi_write(1'b0, 32'h100, 3, 2'b01, -1, 0);
    axi_read(1'b0, 32'h100, 3, 2'b01);
    for (int i = 0; i < 4; i++) begin
      total++;
      if (rbuf[i] !== 32'(i + 1) || lbuf[i] !== (i == 3))
        $display("FAIL incr_beat%0d got %h last%b required %h last%b",
                 i, rbuf[i], lbuf[i], i + 1, (i == 3));
      else passed++;
    end
  endtask

  task automatic test_wrap();
    logic [31:0] exp_at [4];
    for (int i = 0; i < 4; i++) begin wbuf[i] = 32'hC0DE_0000 + 32'(i); sbuf[i] = 4'hF; end
    axi_write(1'b1, 32'h208, 3, 2'b10, -1, 0);
    // Beats 0..3 land at 0x208, 0x20C, 0x200, 0x204
    exp_at[0] = 32'hC0DE_0002; exp_at[1] = 32'hC0DE_0003;
    exp_at[2] = 32'hC0DE_0000; exp_at[3] = 32'hC0DE_0001;
    for (int w = 0; w < 4; w++) begin
      axi_read(1'b0, 32'h200 + 32'(4 * w), 0, 2'b01);
      total++;
      if (rbuf[0] !== exp_at[w])
        $display("FAIL wrap_word%0d got %h required %h", w, rbuf[0], exp_at[w]);
      else passed++;
    end
    axi_read(1'b1, 32'h208, 3, 2'b10);
    for (int i = 0; i < 4; i++) begin
      total++;
      if (rbuf[i] !== wbuf[i]) $display("FAIL wrap_read_beat%0d got %h required %h",
                                        i, rbuf[i], wbuf[i]);
      else passed++;
    end
  endtask

  task automatic test_strobe();
    wbuf[0] = 32'hFFFF_FFFF; sbuf[0] = 4'hF;
    axi_write(1'b0, 32'h300, 0, 2'b01, -1, 0);
    wbuf[0] = 32'h0; sbuf[0] = 4'b0101;
    axi_write(1'b0, 32'h300, 0, 2'b01, -1, 0);
    axi_read(1'b0, 32'h300, 0, 2'b01);
    total++;
    if (rbuf[0] !== 32'hFF00_FF00) $display("FAIL strobe got %h required ff00ff00", rbuf[0]);
    else passed++;
  endtask

  task automatic test_backpressure();
    logic        pat [8];
    logic [31:0] held;
    bit          was_stalled;
    int          beat, cyc;
    pat[0] = 1; pat[1] = 0; pat[2] = 0; pat[3] = 1;
    pat[4] = 1; pat[5] = 1; pat[6] = 1; pat[7] = 1;
    araddr = 32'h100; arlen = 8'd3; arsize = 3'd2; arburst = 2'b01; arid = 1'b0; arvalid = 1'b1;
    wait_hi("arready", arready);
    @(posedge clk); #1;
    arvalid = 1'b0;
    beat = 0; cyc = 0; was_stalled = 0; held = '0;
    while (beat < 4 && cyc < 20) begin
      rready = (cyc < 8) ? pat[cyc] : 1'b1;
      if (was_stalled) begin
        total++;
        if (rvalid !== 1'b1 || rdata !== held)
          $display("FAIL bp_stable cyc%0d got v%b %h required v1 %h", cyc, rvalid, rdata, held);
        else passed++;
      end
      if (rvalid === 1'b1 && rready) begin
        total++;
        if (rdata !== 32'(beat + 1) || rlast !== (beat == 3))
          $display("FAIL bp_beat%0d got %h last%b required %h last%b",
                   beat, rdata, rlast, beat + 1, (beat == 3));
        else passed++;
        beat++;
      end
      was_stalled = (rvalid === 1'b1) && !rready;
      held = rdata;
      @(posedge clk); #1;
      cyc++;
    end
    rready = 1'b0;
    total++;
    if (beat !== 4 || rvalid !== 1'b0)
      $display("FAIL bp_beat_count got %0d v%b required 4 v0", beat, rvalid);
    else passed++;
    wbuf[0] = 32'h5151_7373; sbuf[0] = 4'hF;
    axi_write(1'b1, 32'h104, 0, 2'b01, -1, 5);
    total++;
    if (b_stable !== 1'b1 || b_id !== 1'b1)
      $display("FAIL bp_bvalid_hold got stable%b id%b required stable1 id1", b_stable, b_id);
    else passed++;
  endtask

  task automatic test_collision();
    logic [31:0] old_val, new_val;
    old_val = model[32'h120 >> 2];
    new_val = $urandom;
    awaddr = 32'h120; awlen = 8'd0; awsize = 3'd2; awburst = 2'b01; awid = 1'b0;
    awvalid = 1'b1;
    wait_hi("awready", awready);
    @(posedge clk); #1;
    awvalid = 1'b0;
    wdata = new_val; wstrb = 4'hF; wlast = 1'b1; wvalid = 1'b1;
    araddr = 32'h120; arlen = 8'd0; arsize = 3'd2; arburst = 2'b01; arid = 1'b1;
    arvalid = 1'b1;
    total++;
    if ({wready, arready} !== 2'b11)
      $display("FAIL collision_ready got %b%b required 11", wready, arready);
    else passed++;
    @(posedge clk); #1;
    wvalid = 1'b0; wlast = 1'b0; arvalid = 1'b0;
    model_write(32'h120, new_val, 4'hF);
    total++;
    if ({bvalid, rvalid} !== 2'b11 || rdata !== old_val)
      $display("FAIL collision_old_data got b%b r%b %h required b1 r1 %h",
               bvalid, rvalid, rdata, old_val);
    else passed++;
    bready = 1'b1; rready = 1'b1;
    @(posedge clk); #1;
    bready = 1'b0; rready = 1'b0;
    axi_read(1'b0, 32'h120, 0, 2'b01);
    total++;
    if (rbuf[0] !== new_val) $display("FAIL collision_new_data got %h required %h",
                                      rbuf[0], new_val);
    else passed++;
  endtask

  task automatic test_reset_mid();
    logic [31:0] d0, d1;
    d0 = $urandom; d1 = $urandom;
    awaddr = 32'h380; awlen = 8'd7; awsize = 3'd2; awburst = 2'b01; awid = 1'b1;
    araddr = 32'h100; arlen = 8'd3; arsize = 3'd2; arburst = 2'b01; arid = 1'b0;
    awvalid = 1'b1; arvalid = 1'b1; rready = 1'b0;
    @(posedge clk); #1;
    awvalid = 1'b0; arvalid = 1'b0;
    total++;
    if ({awready, wready, arready, rvalid} !== 4'b0101)
      $display("FAIL dual_accept got aw%b w%b ar%b r%b required aw0 w1 ar0 r1",
               awready, wready, arready, rvalid);
    else passed++;
    wvalid = 1'b1; wstrb = 4'hF; wdata = d0;
    @(posedge clk); #1;
    model_write(32'h380, d0, 4'hF);
    wdata = d1;
    @(posedge clk); #1;
    model_write(32'h384, d1, 4'hF);
    wvalid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    total++;
    if ({awready, wready, bvalid, arready, rvalid, rlast} !== 6'b0)
      $display("FAIL async_reset got aw%b w%b b%b ar%b r%b l%b required all 0",
               awready, wready, bvalid, arready, rvalid, rlast);
    else passed++;
    #3 rst_n = 1'b1;
    @(posedge clk); #1;
    total++;
    if ({awready, wready, arready, rvalid} !== 4'b1010)
      $display("FAIL reset_recover got aw%b w%b ar%b r%b required aw1 w0 ar1 r0",
               awready, wready, arready, rvalid);
    else passed++;
    axi_read(1'b0, 32'h380, 1, 2'b01);
    total++;
    if (rbuf[0] !== model[32'h380 >> 2] || rbuf[1] !== model[32'h384 >> 2])
      $display("FAIL reset_partial_data got %h %h required %h %h",
               rbuf[0], rbuf[1], model[32'h380 >> 2], model[32'h384 >> 2]);
    else passed++;
  endtask

  task automatic test_random();
    logic [1:0]  burst;
    logic [31:0] addr, ea;
    int          len;
    gaps = 1'b1;
    for (int n = 0; n < 16; n++) begin
      burst = 2'($urandom_range(0, 3));
      len   = (burst == 2'b10) ? ((2 << $urandom_range(0, 3)) - 1) : $urandom_range(0, 15);
      addr  = 32'(4 * $urandom_range(0, 239));
      for (int i = 0; i <= len; i++) begin wbuf[i] = $urandom; sbuf[i] = 4'($urandom); end
      axi_write(1'($urandom), addr, len, burst, -1, 0);
      total++;
      if (b_resp !== 2'b00) $display("FAIL rand%0d_bresp got %b required 00", n, b_resp);
      else passed++;
      axi_read(1'($urandom), addr, len, burst);
      for (int i = 0; i <= len; i++) begin
        ea = beat_addr(addr, len, burst, i);
        total++;
        if (rbuf[i] !== model[(ea >> 2) & 32'h3FF] || lbuf[i] !== (i == len))
          $display("FAIL rand%0d_beat%0d addr %h got %h last%b required %h last%b", n, i, ea,
                   rbuf[i], lbuf[i], model[(ea >> 2) & 32'h3FF], (i == len));
        else passed++;
      end
    end
    gaps = 1'b0;
  endtask

`ifdef AXI_SLV_ERR_CHECK_EN
  task automatic test_err_check();
    axi_read(1'b0, 32'h1000, 0, 2'b01);
    total++;
    if (pbuf[0] !== 2'b10 || rbuf[0] !== 32'hDEAD_BEEF)
      $display("FAIL err_read_range got %b %h required 10 deadbeef", pbuf[0], rbuf[0]);
    else passed++;
    for (int i = 0; i < 4; i++) begin wbuf[i] = $urandom; sbuf[i] = 4'hF; end
    axi_write(1'b0, 32'h140, 3, 2'b01, 1, 0);
    total++;
    if (b_resp !== 2'b10) $display("FAIL err_early_wlast got %b required 10", b_resp);
    else passed++;
  endtask
`endif

  initial begin
    awvalid = 0; wvalid = 0; bready = 0; arvalid = 0; rready = 0; wlast = 0;
    awid = 0; awaddr = 0; awlen = 0; awsize = 3'd2; awburst = 2'b01;
    wdata = 0; wstrb = 0;
    arid = 0; araddr = 0; arlen = 0; arsize = 3'd2; arburst = 2'b01;
    test_reset();
    test_single();
    test_full_burst();
    test_incr();
    test_wrap();
    test_strobe();
    test_backpressure();
    test_collision();
    test_reset_mid();
    test_random();
`ifdef AXI_SLV_ERR_CHECK_EN
    test_err_check();
`endif
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
